// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor.
// A single shared 4-bit binary adder with +6 correction handles one digit per
// cycle, least significant digit first. Subtraction adds the nines complement
// of B with an initial carry of 1. A negative difference costs a second pass
// that converts the stored result into its tens complement, so the magnitude
// is what appears on result.
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_out,
    output logic                negative,
    output logic                error
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        FIX,
        DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_busy;
    logic            r_done;
    logic            r_carry_out;
    logic            r_negative;
    logic            r_error;

    logic            w_bad;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_res_dig;
    logic [3:0]      w_op_a;
    logic [3:0]      w_op_b;
    logic [4:0]      w_sum;
    logic            w_dig_carry;
    logic [3:0]      w_digit;

    // Flag any latched operand digit outside 0..9.
    // NOTE: every always_comb output gets a default before any branch or loop,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // Shared digit adder: operands come from A/B during ADD and from the
    // nines complement of the stored result during FIX.
    always_comb begin
        w_a_dig     = r_a[{r_idx, 2'b00} +: 4];
        w_b_dig     = r_b[{r_idx, 2'b00} +: 4];
        w_res_dig   = r_result[{r_idx, 2'b00} +: 4];
        w_op_a      = w_a_dig;
        w_op_b      = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
        if (r_state == FIX) begin
            w_op_a = 4'd9 - w_res_dig;
            w_op_b = 4'd0;
        end
        w_sum       = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'b0000, r_carry};
        w_dig_carry = (w_sum > 5'd9);
        // Low nibble of (sum + 6) is the corrected digit whenever sum > 9.
        w_digit     = w_dig_carry ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
    end

    // Control FSM with registered outputs; done is high exactly while in DONE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
            r_negative  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_sub       <= sub;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_negative  <= 1'b0;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= '0;
                        r_carry <= r_sub;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_result[{r_idx, 2'b00} +: 4] <= w_digit;
                    r_carry                       <= w_dig_carry;
                    if (r_idx == LAST_IDX) begin
                        if (!r_sub) begin
                            r_carry_out <= w_dig_carry;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_dig_carry) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // No end-around carry: A < B, convert to magnitude.
                            r_negative <= 1'b1;
                            r_idx      <= '0;
                            r_carry    <= 1'b1;
                            r_state    <= FIX;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                FIX: begin
                    r_result[{r_idx, 2'b00} +: 4] <= w_digit;
                    r_carry                       <= w_dig_carry;
                    if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign negative  = r_negative;
    assign error     = r_error;

endmodule

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 1-16).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, meaning a request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit, meaning operation select (0 = A+B, 1 = A-B), sampled with start.
REQ-006 The block SHALL have port a, input, 4*DIGITS bits, meaning operand A as packed BCD with digit 0 in bits [3:0], sampled with start.
REQ-007 The block SHALL have port b, input, 4*DIGITS bits, meaning operand B in the same format as a, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit, meaning high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse when result and flags become valid.
REQ-010 The block SHALL have port result, output, 4*DIGITS bits, meaning the BCD result magnitude.
REQ-011 The block SHALL have port carry_out, output, 1 bit, meaning the add result is at least 10^DIGITS.
REQ-012 The block SHALL have port negative, output, 1 bit, meaning the subtract result A-B is less than 0.
REQ-013 The block SHALL have port error, output, 1 bit, meaning an operand digit was greater than 9.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, CHECK, ADD, FIX, DONE.
REQ-015 In IDLE, start=1 SHALL latch a, b and sub, clear result, carry_out, negative and error, and move to CHECK.
REQ-016 CHECK SHALL last 1 cycle: if any latched digit exceeds 9, set error=1, keep result=0, and go to DONE; otherwise go to ADD.
REQ-017 ADD SHALL process one digit per cycle, LSD first, for DIGITS cycles, using one binary 4-bit add per digit plus +6 correction when the binary sum exceeds 9 or carries out.
REQ-018 In ADD with sub=1, the B digit used SHALL be its nines complement (9-b), and the initial carry SHALL be 1; with sub=0, the initial carry SHALL be 0.
REQ-019 The digit carry SHALL propagate between cycles in a 1-bit register, and each corrected digit SHALL be written into result at its position.
REQ-020 At the end of ADD with sub=0, carry_out SHALL equal the final digit carry, and the FSM SHALL go to DONE.
REQ-021 At the end of ADD with sub=1 and a final carry of 1, the result SHALL be positive, negative=0 and carry_out=0, and the FSM SHALL go to DONE.
REQ-022 At the end of ADD with sub=1 and a final carry of 0, negative SHALL be set to 1 and the FSM SHALL go to FIX.
REQ-023 FIX SHALL run DIGITS cycles, replacing result with its tens complement (nines complement plus an initial carry of 1, LSD first); the final carry SHALL be discarded.
REQ-024 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-025 Latency from the start-sampling edge to done high SHALL be:
- 1+DIGITS+1 cycles for add, or for subtract with A>=B;
- 1+2*DIGITS+1 cycles for subtract with A<B;
- 2 cycles for error.
REQ-026 result, carry_out, negative and error SHALL hold their values from done until the next accepted start.
REQ-027 start SHALL be ignored while busy=1, and operand changes during busy SHALL have no effect.
REQ-028 A-B=0 SHALL give result 0 and negative=0.
REQ-029 Sums at or above 10^DIGITS SHALL wrap, giving result = (A+B) mod 10^DIGITS with carry_out=1.
REQ-030 Intermediate result digits MAY be visible before done, and only post-done values SHALL be specified.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with busy, done, result, carry_out, negative and error all 0, and all internal registers cleared.
REQ-032 Reset asserted mid-operation SHALL abort immediately with no done pulse, and the first start after rst deasserts SHALL be accepted normally.

Verification (DIGITS=4)
REQ-033 Add 0999+0001 -> result 1000, carry_out 0, done 6 cycles after start.
REQ-034 Add 9999+0001 -> result 0000, carry_out 1; add 5678+4321 -> 9999, carry_out 0.
REQ-035 Sub 0500-0123 -> result 0377, negative 0, done 6 cycles after start; sub 0042-0042 -> 0000, negative 0.
REQ-036 Sub 0123-0500 -> result 0377, negative 1, done 10 cycles after start.
REQ-037 Operand a=0x00A1 -> error 1, result 0000, done 2 cycles after start; the next valid add completes correctly.
REQ-038 Pulse start again during busy with different operands -> ignored, original result delivered; rst pulse in the middle of ADD -> no done pulse, all outputs 0, and a subsequent operation is correct.
